// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for axi_lite_regbank.
// Handshake rule for every channel: a transfer happens on a rising ACLK edge
// where both VALID and READY are high; the source keeps VALID and its payload
// stable until that edge, and VALID never waits on READY.
interface axi_lite_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS read/write registers with byte
// strobes, independent write and read FSMs, per-register write strobes.
// Optional feature macro AXI_LITE_REGBANK_IRQ_EN: adds a read-only IRQ status
// register at index NUM_REGS and a sticky write-event interrupt.
module axi_lite_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_lite_regbank_if.slave              bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output logic                           irq,
  output logic                           w_state_dbg,
  output logic                           r_state_dbg
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  // First index past the read/write registers (IRQ status slot when enabled).
  localparam logic [IDX_W-1:0] MAP_END = IDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_latched, w_latched;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [1:0]            bresp_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_ok;
  logic [IDX_W-1:0]      ar_idx;

  logic aw_hs, w_hs, ar_hs, r_hs, commit, wr_in_range;

  // Protection bits and byte offsets carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.AWPROT, bus.ARPROT,
                         bus.AWADDR[OFF_W-1:0], bus.ARADDR[OFF_W-1:0]};

  assign aw_hs       = bus.AWVALID && bus.AWREADY;
  assign w_hs        = bus.WVALID && bus.WREADY;
  assign ar_hs       = bus.ARVALID && bus.ARREADY;
  assign r_hs        = bus.RVALID && bus.RREADY;
  assign commit      = (w_state == W_IDLE) && aw_latched && w_latched;
  assign wr_in_range = (aw_idx < MAP_END);
  assign ar_idx      = bus.ARADDR[ADDR_WIDTH-1:OFF_W];

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;
  assign bus.BRESP   = bresp_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

  // ---------------- write FSM ----------------

  // Write state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  // Write next state: commit once both halves are held, leave on B handshake.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_latched && w_latched) w_state_nxt = W_RESP;
      W_RESP:  if (bus.BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write outputs: each channel ready only until its own half is latched.
  always_comb begin
    bus.AWREADY = (w_state == W_IDLE) && !aw_latched;
    bus.WREADY  = (w_state == W_IDLE) && !w_latched;
    bus.BVALID  = (w_state == W_RESP);
  end

  // Capture AW and W independently; both are consumed by the commit.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      aw_idx     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
    end else if (commit) begin
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_latched <= 1'b1;
        aw_idx     <= bus.AWADDR[ADDR_WIDTH-1:OFF_W];
      end
      if (w_hs) begin
        w_latched <= 1'b1;
        w_data    <= bus.WDATA;
        w_strb    <= bus.WSTRB;
      end
    end
  end

  // Register file update with byte strobes, write strobe and write response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      reg_wr_pulse <= '0;
      bresp_q      <= RESP_OKAY;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (aw_idx == IDX_W'(k)) begin
            reg_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb[b]) regs[k][b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------- read FSM ----------------

  // Read state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  // Read next state: one-cycle latency to data, hold until R handshake.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (bus.ARVALID) r_state_nxt = R_DATA;
      R_DATA:  if (bus.RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read outputs.
  always_comb begin
    bus.ARREADY = (r_state == R_IDLE);
    bus.RVALID  = (r_state == R_DATA);
  end

  // Read decode; register values are the pre-commit ones at the AR edge.
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_val = regs[k];
        rd_ok  = 1'b1;
      end
    end
`ifdef AXI_LITE_REGBANK_IRQ_EN
    if (ar_idx == MAP_END) begin
      rd_val = {{(DATA_WIDTH-1){1'b0}}, irq};
      rd_ok  = 1'b1;
    end
`endif
  end

  // Sample read data and response on the AR handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_val;
      rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

`ifdef AXI_LITE_REGBANK_IRQ_EN
  logic rd_irq;

  // Remember whether the outstanding read targets the IRQ status register.
  always_ff @(posedge ACLK) begin
    if (ARESET)     rd_irq <= 1'b0;
    else if (ar_hs) rd_irq <= (ar_idx == MAP_END);
  end

  // Sticky interrupt: set by any in-range commit, cleared by reading status;
  // a set in the clearing cycle wins.
  always_ff @(posedge ACLK) begin
    if (ARESET)                     irq <= 1'b0;
    else if (commit && wr_in_range) irq <= 1'b1;
    else if (r_hs && rd_irq)        irq <= 1'b0;
  end
`else
  assign irq = 1'b0;
  logic unused_r_hs;
  assign unused_r_hs = r_hs;
`endif

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank with a B/R response scoreboard.
module tb_axi_lite_regbank;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int AW  = 8;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;
  logic             irq, w_state_dbg, r_state_dbg;

  int checks = 0;
  int errors = 0;

  logic [1:0]    exp_b_q[$];
  logic [DW+1:0] exp_r_q[$];

  axi_lite_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .bus          (bus.slave),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse),
    .irq          (irq),
    .w_state_dbg  (w_state_dbg),
    .r_state_dbg  (r_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles", name, TMO);
  endtask

  task automatic check_regs(input logic [DW-1:0] e0, e1, e2, e3);
    check("reg0", reg_out[0*DW +: DW], e0);
    check("reg1", reg_out[1*DW +: DW], e1);
    check("reg2", reg_out[2*DW +: DW], e2);
    check("reg3", reg_out[3*DW +: DW], e3);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.BVALID && bus.BREADY) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bresp %0h, expected none", bus.BRESP);
      end else begin
        check("bresp", bus.BRESP, exp_b_q.pop_front());
      end
    end
    if (!rst && bus.RVALID && bus.RREADY) begin
      if (exp_r_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got rdata %0h, expected none", bus.RDATA);
      end else begin
        check("rresp_rdata", {bus.RRESP, bus.RDATA}, exp_r_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic send_aw(input logic [AW-1:0] addr);
    int n = 0;
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    @(negedge clk);
    while (!bus.AWREADY && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) timeout("aw_handshake");
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    int n = 0;
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
    @(negedge clk);
    while (!bus.WREADY && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) timeout("w_handshake");
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] addr);
    int n = 0;
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    @(negedge clk);
    while (!bus.ARREADY && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) timeout("ar_handshake");
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  // Accept B; the first BVALID cycle is also where the write strobe shows.
  task automatic wait_b(input logic [NR-1:0] exp_pulse);
    int n = 0;
    bus.BREADY = 1'b1;
    @(negedge clk);
    while (!bus.BVALID && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) timeout("b_wait");
    else check("wr_pulse", reg_wr_pulse, exp_pulse);
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic wait_r();
    int n = 0;
    bus.RREADY = 1'b1;
    @(negedge clk);
    while (!bus.RVALID && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) timeout("r_wait");
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
  endtask

  // Leaves at the negedge where BVALID is first seen.
  task automatic wait_bvalid();
    int n = 0;
    @(negedge clk);
    while (!bus.BVALID && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) timeout("bvalid_wait");
  endtask

  task automatic write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [3:0] strb, input logic [1:0] resp,
                       input logic [NR-1:0] pulse);
    exp_b_q.push_back(resp);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
    wait_b(pulse);
  endtask

  task automatic read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [1:0] resp);
    exp_r_q.push_back({resp, data});
    send_ar(addr);
    wait_r();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.AWADDR = '0; bus.AWPROT = 3'b0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = 3'b0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_awready", bus.AWREADY, 1);
    check("rst_wready", bus.WREADY, 1);
    check("rst_arready", bus.ARREADY, 1);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    check("rst_irq", irq, 0);
    check_regs(0, 0, 0, 0);
    @(posedge clk); #1;

    // Basic writes and read-back
    write(8'h00, 32'h1, 4'hF, 2'b00, 4'b0001);
    write(8'h04, 32'h2, 4'hF, 2'b00, 4'b0010);
    write(8'h08, 32'h3, 4'hF, 2'b00, 4'b0100);
    write(8'h0C, 32'h4, 4'hF, 2'b00, 4'b1000);
    check_regs(32'h1, 32'h2, 32'h3, 32'h4);
    read(8'h00, 32'h1, 2'b00);
    read(8'h04, 32'h2, 2'b00);
    read(8'h08, 32'h3, 2'b00);
    read(8'h0C, 32'h4, 2'b00);
`ifndef AXI_LITE_REGBANK_IRQ_EN
    check("irq_tied", irq, 0);
`endif

    // W one cycle before AW, partial strobe
    exp_b_q.push_back(2'b00);
    fork
      send_w(32'hA5A5A5A5, 4'b0011);
      begin @(posedge clk); #1; send_aw(8'h04); end
    join
    wait_b(4'b0010);
    check("reg1_w_first", reg_out[1*DW +: DW], 32'h0000A5A5);
    write(8'h04, 32'h2, 4'hF, 2'b00, 4'b0010);
    check("reg1_restore", reg_out[1*DW +: DW], 32'h2);
    // AW one cycle before W
    exp_b_q.push_back(2'b00);
    fork
      send_aw(8'h04);
      begin @(posedge clk); #1; send_w(32'hA5A5A5A5, 4'b0011); end
    join
    wait_b(4'b0010);
    check("reg1_aw_first", reg_out[1*DW +: DW], 32'h0000A5A5);

    // Out-of-range access and ignored byte offset
    write(8'h40, 32'hDEADBEEF, 4'hF, 2'b10, 4'b0000);
    check_regs(32'h1, 32'h0000A5A5, 32'h3, 32'h4);
    read(8'h40, 32'h0, 2'b10);
    read(8'h0E, 32'h4, 2'b00);
`ifndef AXI_LITE_REGBANK_IRQ_EN
    read(8'h10, 32'h0, 2'b10);
    write(8'h10, 32'h5, 4'hF, 2'b10, 4'b0000);
    check_regs(32'h1, 32'h0000A5A5, 32'h3, 32'h4);
`endif

    // Write response back-pressure
    exp_b_q.push_back(2'b00);
    fork
      send_aw(8'h0C);
      send_w(32'h55, 4'hF);
    join
    wait_bvalid();
    check("stall_pulse", reg_wr_pulse, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_bvalid", bus.BVALID, 1);
      check("stall_bresp", bus.BRESP, 2'b00);
      check("stall_awready", bus.AWREADY, 0);
      check("stall_wready", bus.WREADY, 0);
    end
    @(posedge clk); #1;
    wait_b(4'b0000);
    check("reg3_stall", reg_out[3*DW +: DW], 32'h55);

    // Read response back-pressure
    exp_r_q.push_back({2'b00, 32'h0000A5A5});
    send_ar(8'h04);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rvalid", bus.RVALID, 1);
      check("stall_rdata", bus.RDATA, 32'h0000A5A5);
      check("stall_arready", bus.ARREADY, 0);
    end
    @(posedge clk); #1;
    wait_r();

    // AR handshake on the commit edge of a write to the same register
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back({2'b00, 32'h3});
    fork
      send_aw(8'h08);
      send_w(32'h9, 4'hF);
    join
    fork
      send_ar(8'h08);
      wait_b(4'b0100);
    join
    wait_r();
    read(8'h08, 32'h9, 2'b00);

    // Reset during W_RESP abandons the response
    fork
      send_aw(8'h00);
      send_w(32'hAB, 4'hF);
    join
    wait_bvalid();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_bvalid", bus.BVALID, 0);
    check("mid_rst_pulse", reg_wr_pulse, 0);
    check_regs(0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", bus.AWREADY, 1);
    check("post_rst_wready", bus.WREADY, 1);
    check("post_rst_arready", bus.ARREADY, 1);
    @(posedge clk); #1;
    write(8'h00, 32'h77, 4'hF, 2'b00, 4'b0001);
    check("reg0_post_rst", reg_out[0*DW +: DW], 32'h77);
    read(8'h00, 32'h77, 2'b00);

`ifdef AXI_LITE_REGBANK_IRQ_EN
    // Interrupt set / clear / set-wins
    check("irq_set", irq, 1);
    read(8'h10, 32'h1, 2'b00);
    check("irq_cleared", irq, 0);
    write(8'h10, 32'h5, 4'hF, 2'b10, 4'b0000);
    check("irq_after_slverr", irq, 0);
    write(8'h04, 32'h12, 4'hF, 2'b00, 4'b0010);
    check("irq_set2", irq, 1);
    exp_r_q.push_back({2'b00, 32'h1});
    send_ar(8'h10);
    exp_b_q.push_back(2'b00);
    fork
      send_aw(8'h0C);
      send_w(32'h66, 4'hF);
    join
    fork
      wait_r();
      wait_b(4'b1000);
    join
    check("irq_set_wins", irq, 1);
`else
    check("irq_tied_end", irq, 0);
`endif

    // Final report
    repeat (3) @(posedge clk);
    check("exp_b_q_empty", exp_b_q.size(), 0);
    check("exp_r_q_empty", exp_r_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
